// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] so,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    LAST  = IW'(N - 1);
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa, opb, res, res_next;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic             accept;
    logic             last;
    int               shamt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign last = (state == RUN) && (idx == LAST);

    // Shifts instead of indexed part-selects keep the chunk select width-clean for any N.
    always_comb begin
        shamt     = int'(idx) * CHUNK;
        a_sh      = opa >> shamt;
        b_sh      = opb >> shamt;
        a_chunk   = a_sh[CHUNK-1:0];
        b_chunk   = b_sh[CHUNK-1:0];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        // Carry into a bit position is its sum bit xor its operand bits.
        msb_cin   = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        res_next  = (res & ~(CMASK << shamt)) | (WIDTH'(chunk_sum[CHUNK-1:0]) << shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            so    <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            res   <= res_next;
            carry <= chunk_sum[CHUNK];
            if (last) begin
                so  <= res_next;
                co  <= chunk_sum[CHUNK];
                ovf <= msb_cin ^ chunk_sum[CHUNK];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule
